if_fetch_unit: RTL

Instruction-fetch stage that consumes the selected next-PC from the next-PC selector and returns the sequential `nPC` to it. It holds the program counter, drives a single-outstanding request/ready handshake to instruction memory, and loads the IF/ID pipeline register. It also honours hazard stalls through a one-entry skid buffer and squashes wrong-path fetches on a branch or jump redirect.

---
 rtl/if_fetch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, skid buffer, IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch/squash counters.
module if_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] PC_in,
   input  logic        redirect,
   input  logic        stall,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_data,
   output logic [15:0] nPC,
   output logic [15:0] PC_IF,
   output logic [31:0] IR_out,
   output logic        valid_IF,
   output logic [15:0] fetch_cnt,
   output logic [15:0] squash_cnt
);

   typedef enum logic [1:0] {RUN, KILL, SKID} state_t;

   state_t      state, state_nx;
   logic [15:0] pc, addr_q, skid_pc;
   logic [31:0] skid_ir;
   logic        pend, skid_full;
   logic        launch, done;

   assign nPC = pc + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (redirect) begin
         state_nx = (pend && !imem_rdy) ? KILL : RUN;
      end else begin
         unique case (state)
            RUN:     if (done && stall) state_nx = SKID;
            KILL:    if (imem_rdy) state_nx = RUN;
            SKID:    if (!stall) state_nx = RUN;
            default: state_nx = RUN;
         endcase
      end
   end

   // A new request needs a free IF/ID slot; a pending one is held regardless.
   always_comb begin
      launch    = (state == RUN) && !pend && !(valid_IF && stall);
      imem_req  = !rst && (pend || launch);
      imem_addr = pend ? addr_q : pc;
      done      = imem_req && imem_rdy;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= RESET_PC;
         addr_q    <= 16'h0000;
         pend      <= 1'b0;
         skid_pc   <= 16'h0000;
         skid_ir   <= 32'h0;
         skid_full <= 1'b0;
         PC_IF     <= 16'h0000;
         IR_out    <= 32'h0;
         valid_IF  <= 1'b0;
      end else begin
         if (launch) addr_q <= pc;
         if (redirect) begin
            pc        <= PC_in;
            valid_IF  <= 1'b0;
            skid_full <= 1'b0;
            pend      <= pend && !imem_rdy;
         end else begin
            pend <= imem_req && !imem_rdy;
            if (state == RUN && done) pc <= PC_in;
            if (state == RUN && done && !stall) begin
               PC_IF    <= imem_addr;
               IR_out   <= imem_data;
               valid_IF <= 1'b1;
            end else if (state == RUN && done) begin
               skid_pc   <= imem_addr;
               skid_ir   <= imem_data;
               skid_full <= 1'b1;
            end else if (state == SKID && !stall) begin
               PC_IF     <= skid_pc;
               IR_out    <= skid_ir;
               valid_IF  <= skid_full;
               skid_full <= 1'b0;
            end else if (!stall) begin
               valid_IF <= 1'b0;
            end
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] fcnt, scnt;
   logic        kept, dropped;

   assign kept    = done && !redirect && (state == RUN);
   assign dropped = done && (redirect || state == KILL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt <= 16'h0000;
         scnt <= 16'h0000;
      end else begin
         if (kept && fcnt != 16'hFFFF)    fcnt <= fcnt + 16'd1;
         if (dropped && scnt != 16'hFFFF) scnt <= scnt + 16'd1;
      end
   end

   assign fetch_cnt  = fcnt;
   assign squash_cnt = scnt;
`else
   assign fetch_cnt  = 16'h0000;
   assign squash_cnt = 16'h0000;
`endif

endmodule
